// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3 constants and types.
// Used by all AHB3 peripherals in this slice.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } mem_state_t;

endpackage

// File: rtl/peripheral_ahb3_byte_enable.sv
// Byte-lane enables from transfer size and address offset.
// Lanes are aligned down to the transfer size.
module peripheral_ahb3_byte_enable #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  logic [HADDR_SIZE-1:0]   HADDR,
    input  logic [2:0]              HSIZE,
    output logic [HDATA_SIZE/8-1:0] byte_en
);

    localparam int BW = HDATA_SIZE / 8;

    int nbytes;
    int off;
    int base;

    // Enable the contiguous lanes covered by the transfer
    always_comb begin
        byte_en = '0;
        nbytes  = 1 << int'(HSIZE);
        off     = int'(HADDR % HADDR_SIZE'(BW));
        base    = off & ~(nbytes - 1);
        for (int i = 0; i < BW; i++) begin
            byte_en[i] = (i >= base) && (i < base + nbytes);
        end
    end

endmodule

// File: rtl/peripheral_ahb3_slave_mem.sv
// AHB3-Lite memory slave with wait states
// and two-cycle error response.
module peripheral_ahb3_slave_mem #(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    import peripheral_ahb3_pkg::*;

    localparam int BW   = HDATA_SIZE / 8;
    localparam int OFFW = $clog2(BW);
    localparam int IW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    mem_state_t state, state_nxt;
    logic [3:0] wcnt, wcnt_nxt;

    logic                  dp_valid;
    logic                  dp_write;
    logic [HADDR_SIZE-1:0] dp_addr;
    logic [2:0]            dp_size;
    logic [IW-1:0]         dp_idx;

    logic accept, req_err, slave_ready, complete, mem_we;
    logic err_range, err_size, err_align;
    logic [HADDR_SIZE-1:0] req_widx, size_mask;
    logic [BW-1:0] byte_en;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    assign slave_ready = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept = HSEL && HREADY && slave_ready &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    assign req_widx  = HADDR >> OFFW;
    assign size_mask = HADDR_SIZE'((32'd1 << HSIZE) - 32'd1);
    assign err_range = {1'b0, req_widx} >= (HADDR_SIZE+1)'(MEM_DEPTH);
    assign err_size  = 32'(HSIZE) > 32'(OFFW);
    assign err_align = |(HADDR & size_mask);
    assign req_err   = err_range || err_size || err_align;

    assign dp_idx   = IW'(dp_addr >> OFFW);
    assign complete = (state == ST_IDLE) && dp_valid;
    assign mem_we   = complete && dp_write;

    assign HREADYOUT = slave_ready;
    assign HRESP = (state == ST_ERR1 || state == ST_ERR2) ?
                   HRESP_ERROR : HRESP_OKAY;
    assign HRDATA = (complete && !dp_write) ? mem[dp_idx] : '0;

    peripheral_ahb3_byte_enable #(
        .HADDR_SIZE (HADDR_SIZE),
        .HDATA_SIZE (HDATA_SIZE)
    ) u_be (
        .HADDR   (dp_addr),
        .HSIZE   (dp_size),
        .byte_en (byte_en)
    );

    // State and wait-counter registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next state: accept in IDLE/ERR2, count down in WAIT
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                wcnt_nxt = wcnt - 4'd1;
                if (wcnt <= 4'd1) begin
                    state_nxt = ST_IDLE;
                    wcnt_nxt  = '0;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
        endcase
    end

    // Data-phase context captured at acceptance
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
        end else if (slave_ready) begin
            dp_valid <= accept && !req_err;
            if (accept) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR;
                dp_size  <= HSIZE;
            end
        end
    end

    // Byte-lane write in the completing cycle; contents survive reset
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < BW; i++) begin
                if (byte_en[i]) begin
                    mem[dp_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule
